// File: rtl/hangman_round_engine.sv
// One hangman round: P1 enters a word, P2 guesses, all positions matched in parallel, scores saturate.
// Optional round timer enabled by defining ROUND_TIMER_EN (time_o tied to 0 otherwise).
module hangman_round_engine #(
    parameter int CHAR_W   = 5,
    parameter int MAX_LEN  = 8,
    parameter int MAX_MISS = 9,
    parameter int SCORE_W  = 4,
    parameter int TIME_LIM = 60
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [CHAR_W-1:0]             char_i,
    input  logic                          load_i,
    input  logic                          word_done_i,
    input  logic                          guess_i,
    input  logic                          tick_i,
    input  logic                          new_round_i,
    output logic [$clog2(MAX_LEN+1)-1:0]  word_len_o,
    output logic [MAX_LEN-1:0]            reveal_o,
    output logic [$clog2(MAX_MISS+1)-1:0] miss_o,
    output logic                          hit_o,
    output logic                          repeat_o,
    output logic [2:0]                    state_o,
    output logic [6:0]                    time_o,
    output logic [SCORE_W-1:0]            p1score_o,
    output logic [SCORE_W-1:0]            p2score_o
);

    localparam int LEN_W  = $clog2(MAX_LEN+1);
    localparam int MISS_W = $clog2(MAX_MISS+1);

    typedef enum logic [2:0] {
        S_ENTRY = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [CHAR_W-1:0]   word_q [MAX_LEN];
    logic [LEN_W-1:0]    len_q;
    logic [MAX_LEN-1:0]  reveal_q;
    logic [MISS_W-1:0]   miss_q;
    logic                hit_q;
    logic                repeat_q;
    logic [CHAR_W-1:0]   guess_q;
    logic [SCORE_W-1:0]  p1score_q;
    logic [SCORE_W-1:0]  p2score_q;

    logic [MAX_LEN-1:0]  eq;
    logic [MAX_LEN-1:0]  len_mask;
    logic [MAX_LEN-1:0]  reveal_d;
    logic [LEN_W-1:0]    len_d;
    logic [MISS_W-1:0]   miss_d;
    logic                load_ok;
    logic                done_ok;
    logic                win_c;
    logic                lose_c;
    logic                expire;

    always_comb begin
        eq       = '0;
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
            eq[i]       = len_mask[i] && (word_q[i] == guess_q);
        end
    end

    // A load in the same cycle as word_done counts toward the length that done sees.
    assign load_ok  = (state_q == S_ENTRY) && load_i && (char_i != '0) && (len_q < LEN_W'(MAX_LEN));
    assign len_d    = load_ok ? len_q + LEN_W'(1) : len_q;
    assign done_ok  = (state_q == S_ENTRY) && word_done_i && (len_d != '0);
    assign reveal_d = reveal_q | eq;
    assign miss_d   = miss_q + MISS_W'(1);
    assign win_c    = (reveal_d == len_mask);
    assign lose_c   = ((eq == '0) && (miss_d == MISS_W'(MAX_MISS))) || expire;

`ifdef ROUND_TIMER_EN
    logic [6:0] time_q;
    logic       tick_dec;
    assign tick_dec = tick_i && ((state_q == S_PLAY) || (state_q == S_CHECK));
    assign expire   = tick_dec && (time_q == 7'd1);
    assign time_o   = time_q;
`else
    logic unused_tick;
    assign unused_tick = tick_i | (TIME_LIM == 0);
    assign expire      = 1'b0;
    assign time_o      = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_ENTRY;
            len_q     <= '0;
            reveal_q  <= '0;
            miss_q    <= '0;
            hit_q     <= 1'b0;
            repeat_q  <= 1'b0;
            guess_q   <= '0;
            p1score_q <= '0;
            p2score_q <= '0;
            for (int i = 0; i < MAX_LEN; i++) word_q[i] <= '0;
`ifdef ROUND_TIMER_EN
            time_q    <= '0;
`endif
        end else begin
            hit_q    <= 1'b0;
            repeat_q <= 1'b0;
`ifdef ROUND_TIMER_EN
            if (tick_dec) time_q <= time_q - 7'd1;
`endif
            case (state_q)
                S_ENTRY: begin
                    if (load_ok) begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (LEN_W'(i) == len_q) word_q[i] <= char_i;
                        len_q <= len_d;
                    end
                    if (done_ok) begin
                        state_q  <= S_PLAY;
                        reveal_q <= '0;
                        miss_q   <= '0;
`ifdef ROUND_TIMER_EN
                        time_q   <= 7'(TIME_LIM);
`endif
                    end
                end
                S_PLAY: begin
                    if (expire) begin
                        state_q <= S_LOSE;
                        if (p1score_q != '1) p1score_q <= p1score_q + SCORE_W'(1);
                    end else if (guess_i) begin
                        guess_q <= char_i;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((eq & ~reveal_q) != '0) begin
                        reveal_q <= reveal_d;
                        hit_q    <= 1'b1;
                    end else if (eq != '0) begin
                        repeat_q <= 1'b1;
                    end else begin
                        miss_q   <= miss_d;
                    end
                    // A winning guess beats a timer expiring in the same cycle.
                    if (win_c) begin
                        state_q <= S_WIN;
                        if (p2score_q != '1) p2score_q <= p2score_q + SCORE_W'(1);
                    end else if (lose_c) begin
                        state_q <= S_LOSE;
                        if (p1score_q != '1) p1score_q <= p1score_q + SCORE_W'(1);
                    end else begin
                        state_q <= S_PLAY;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (new_round_i) begin
                        state_q  <= S_ENTRY;
                        len_q    <= '0;
                        reveal_q <= '0;
                        miss_q   <= '0;
                    end
                end
                default: state_q <= S_ENTRY;
            endcase
        end
    end

    assign word_len_o = len_q;
    assign reveal_o   = reveal_q;
    assign miss_o     = miss_q;
    assign hit_o      = hit_q;
    assign repeat_o   = repeat_q;
    assign state_o    = state_q;
    assign p1score_o  = p1score_q;
    assign p2score_o  = p2score_q;

endmodule

// File: tb/tb_hangman_round_engine.sv
// Bench for hangman_round_engine: directed vector table, hand sequences, random ops against a word/set model.
module tb_hangman_round_engine;

    localparam int OP_LOAD  = 0;
    localparam int OP_DONE  = 1;
    localparam int OP_GUESS = 2;
    localparam int OP_NEW   = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] char_i;
    logic       load_i, word_done_i, guess_i, tick_i, new_round_i;
    logic [3:0] word_len_o;
    logic [7:0] reveal_o;
    logic [3:0] miss_o;
    logic       hit_o, repeat_o;
    logic [2:0] state_o;
    logic [6:0] time_o;
    logic [3:0] p1score_o, p2score_o;

    hangman_round_engine dut (
        .clk(clk), .resetn(resetn), .char_i(char_i), .load_i(load_i),
        .word_done_i(word_done_i), .guess_i(guess_i), .tick_i(tick_i),
        .new_round_i(new_round_i), .word_len_o(word_len_o), .reveal_o(reveal_o),
        .miss_o(miss_o), .hit_o(hit_o), .repeat_o(repeat_o), .state_o(state_o),
        .time_o(time_o), .p1score_o(p1score_o), .p2score_o(p2score_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the word as a queue of chars, revealed positions as flags.
    int m_word[$];
    bit m_rev[8];
    int m_miss, m_st, m_p1, m_p2, m_hit, m_rep;

    function automatic void model_reset();
        m_word.delete();
        foreach (m_rev[i]) m_rev[i] = 1'b0;
        m_miss = 0; m_st = 0; m_p1 = 0; m_p2 = 0; m_hit = 0; m_rep = 0;
    endfunction

    function automatic void model_apply(int op, int ch);
        int matched, fresh, shown;
        m_hit = 0;
        m_rep = 0;
        if (op == OP_LOAD && m_st == 0 && ch != 0 && m_word.size() < 8) m_word.push_back(ch);
        else if (op == OP_DONE && m_st == 0 && m_word.size() > 0) begin
            m_st = 1; m_miss = 0;
            foreach (m_rev[i]) m_rev[i] = 1'b0;
        end else if (op == OP_GUESS && m_st == 1) begin
            matched = 0; fresh = 0;
            foreach (m_word[i]) if (m_word[i] == ch) begin
                matched++;
                if (!m_rev[i]) begin fresh++; m_rev[i] = 1'b1; end
            end
            if (fresh > 0) m_hit = 1;
            else if (matched > 0) m_rep = 1;
            else m_miss++;
            shown = 0;
            foreach (m_word[i]) if (m_rev[i]) shown++;
            if (shown == m_word.size()) begin m_st = 3; m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15; end
            else if (m_miss == 9) begin m_st = 4; m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15; end
        end else if (op == OP_NEW && (m_st == 3 || m_st == 4)) begin
            m_st = 0; m_miss = 0; m_word.delete();
            foreach (m_rev[i]) m_rev[i] = 1'b0;
        end
    endfunction

    function automatic logic [7:0] model_reveal();
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = m_rev[i];
        return r;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".len"},    word_len_o, m_word.size());
        chk({tag, ".reveal"}, reveal_o,   model_reveal());
        chk({tag, ".miss"},   miss_o,     m_miss);
        chk({tag, ".state"},  state_o,    m_st);
        chk({tag, ".hit"},    hit_o,      m_hit);
        chk({tag, ".repeat"}, repeat_o,   m_rep);
        chk({tag, ".p1"},     p1score_o,  m_p1);
        chk({tag, ".p2"},     p2score_o,  m_p2);
`ifndef ROUND_TIMER_EN
        chk({tag, ".time"},   time_o,     0);
`endif
    endtask

    // Called at a negedge: pulse for one cycle, idle one cycle, return at a negedge ready to sample.
    task automatic apply(input int op, input int ch);
        char_i      = ch[4:0];
        load_i      = (op == OP_LOAD);
        word_done_i = (op == OP_DONE);
        guess_i     = (op == OP_GUESS);
        new_round_i = (op == OP_NEW);
        @(negedge clk);
        load_i = 1'b0; word_done_i = 1'b0; guess_i = 1'b0; new_round_i = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int op; int ch;
        int len; int rev; int miss; int st; int p1; int p2; int hit; int rep;
    } vec_t;
    vec_t tbl[12];

    initial begin
        tbl[0]  = '{OP_LOAD,  3, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{OP_LOAD,  1, 2, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{OP_LOAD,  3, 3, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{OP_DONE,  0, 3, 0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{OP_GUESS, 3, 3, 5, 0, 1, 0, 0, 1, 0};
        tbl[5]  = '{OP_GUESS, 3, 3, 5, 0, 1, 0, 0, 0, 1};
        tbl[6]  = '{OP_GUESS, 7, 3, 5, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{OP_GUESS, 1, 3, 7, 1, 3, 0, 1, 1, 0};
        tbl[8]  = '{OP_GUESS, 1, 3, 7, 1, 3, 0, 1, 0, 0};
        tbl[9]  = '{OP_NEW,   0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{OP_DONE,  0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[11] = '{OP_LOAD,  0, 0, 0, 0, 0, 0, 1, 0, 0};

        resetn = 1'b0; char_i = '0; load_i = 1'b0; word_done_i = 1'b0;
        guess_i = 1'b0; tick_i = 1'b0; new_round_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.state", state_o, 0);
        chk("rst.len", word_len_o, 0);
        chk("rst.reveal", reveal_o, 0);
        chk("rst.miss", miss_o, 0);
        chk("rst.scores", {p1score_o, p2score_o}, 0);
        chk("rst.pulses", {hit_o, repeat_o}, 0);
        chk("rst.time", time_o, 0);
        resetn = 1'b1;
        @(negedge clk);

        foreach (tbl[k]) begin
            apply(tbl[k].op, tbl[k].ch);
            chk($sformatf("v%0d.len", k),    word_len_o, tbl[k].len);
            chk($sformatf("v%0d.reveal", k), reveal_o,   tbl[k].rev);
            chk($sformatf("v%0d.miss", k),   miss_o,     tbl[k].miss);
            chk($sformatf("v%0d.state", k),  state_o,    tbl[k].st);
            chk($sformatf("v%0d.p1", k),     p1score_o,  tbl[k].p1);
            chk($sformatf("v%0d.p2", k),     p2score_o,  tbl[k].p2);
            chk($sformatf("v%0d.hit", k),    hit_o,      tbl[k].hit);
            chk($sformatf("v%0d.repeat", k), repeat_o,   tbl[k].rep);
        end

        // Fill to capacity; the ninth load must be dropped. Then lose by misses.
        for (int i = 1; i <= 9; i++) begin
            apply(OP_LOAD, 4);
            chk($sformatf("full.len%0d", i), word_len_o, (i > 8) ? 8 : i);
        end
        apply(OP_DONE, 0);
        chk("full.play", state_o, 1);
        for (int i = 1; i <= 10; i++) begin
            apply(OP_GUESS, 2);
            chk($sformatf("miss.cnt%0d", i), miss_o, (i > 9) ? 9 : i);
            chk($sformatf("miss.state%0d", i), state_o, (i >= 9) ? 4 : 1);
        end
        chk("miss.p1", p1score_o, 1);
        apply(OP_NEW, 0);
        chk("miss.new", state_o, 0);

        // Load and done in the same cycle: done sees the new length.
        char_i = 5'd6; load_i = 1'b1; word_done_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0; word_done_i = 1'b0;
        @(negedge clk);
        chk("ld_done.len", word_len_o, 1);
        chk("ld_done.state", state_o, 1);
        apply(OP_GUESS, 6);
        chk("ld_done.win", state_o, 3);
        chk("ld_done.hit", hit_o, 1);
        chk("ld_done.p2", p2score_o, 2);
        @(negedge clk);
        chk("ld_done.hit_gone", hit_o, 0);
        apply(OP_NEW, 0);

        // Repeated losses: p1 score must stick at 15.
        for (int r = 0; r < 15; r++) begin
            apply(OP_LOAD, 1);
            apply(OP_DONE, 0);
            repeat (9) apply(OP_GUESS, 2);
            chk($sformatf("sat.p1_r%0d", r), p1score_o, (r + 2 > 15) ? 15 : r + 2);
            apply(OP_NEW, 0);
        end
        chk("sat.p2", p2score_o, 2);

        // Asynchronous reset in the middle of a round clears everything, scores included.
        apply(OP_LOAD, 5);
        apply(OP_LOAD, 6);
        apply(OP_DONE, 0);
        apply(OP_GUESS, 5);
        chk("mid.reveal", reveal_o, 1);
        #2 resetn = 1'b0;
        #1;
        chk("mid.state", state_o, 0);
        chk("mid.len", word_len_o, 0);
        chk("mid.reveal0", reveal_o, 0);
        chk("mid.scores", {p1score_o, p2score_o}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        model_reset();
        for (int n = 0; n < 1500; n++) begin
            int sel, op, ch;
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? OP_LOAD : (sel == 4) ? OP_DONE : (sel < 9) ? OP_GUESS : OP_NEW;
            ch  = $urandom_range(0, 5);
            apply(op, ch);
            model_apply(op, ch);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
